// File: rtl/jk_pkg.sv
// Shared types and helpers for the JK excitation driver: FSM states, the
// JK excitation table and the JK next-state equation.
package jk_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        HOLD  = 2'd2
    } drv_state_t;

    // Returns {J,K} that moves a JK flop from q to t; don't-care bits take fill.
    function automatic logic [1:0] jk_excite(input logic q, input logic t, input logic fill);
        logic [1:0] w_jk;
        case ({q, t})
            2'b00:   w_jk = {1'b0, fill};
            2'b01:   w_jk = {1'b1, fill};
            2'b10:   w_jk = {fill, 1'b1};
            default: w_jk = {fill, 1'b0};
        endcase
        return w_jk;
    endfunction

    function automatic logic jk_next(input logic q, input logic j, input logic k);
        logic w_q;
        case ({j, k})
            2'b00:   w_q = q;
            2'b10:   w_q = 1'b1;
            2'b01:   w_q = 1'b0;
            default: w_q = ~q;
        endcase
        return w_q;
    endfunction

endpackage

// File: rtl/jk_target_fifo.sv
// DEPTH x 1-bit target FIFO with occupancy count; pointers wrap naturally
// because DEPTH is a power of two.
module jk_target_fifo #(
    parameter int DEPTH = 4,
    parameter int LVL_W = $clog2(DEPTH) + 1
) (
    input  logic             clock,
    input  logic             clear,
    input  logic             i_push,
    input  logic             i_pushData,
    input  logic             i_pop,
    output logic             o_popData,
    output logic [LVL_W-1:0] o_level
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic             r_mem [DEPTH];
    logic [PTR_W-1:0] r_wrPtr;
    logic [PTR_W-1:0] r_rdPtr;
    logic [LVL_W-1:0] r_level;

    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_level <= '0;
        end else begin
            if (i_push) r_wrPtr <= r_wrPtr + 1'b1;
            if (i_pop)  r_rdPtr <= r_rdPtr + 1'b1;
            case ({i_push, i_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end

    // Storage needs no reset: occupancy alone decides what is valid.
    always_ff @(posedge clock) begin
        if (i_push) r_mem[r_wrPtr] <= i_pushData;
    end

    assign o_popData = r_mem[r_rdPtr];
    assign o_level   = r_level;

endmodule

// File: rtl/jk_excitation_driver.sv
// Drives J/K of an external JK flop so its Q follows a queue of target values,
// and watches the fed-back Q against an internal JK model.
module jk_excitation_driver
    import jk_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int ERR_W = 8
) (
    input  logic                     clock,
    input  logic                     clear,
    input  logic                     tgt_valid,
    output logic                     tgt_ready,
    input  logic                     tgt_q,
    input  logic                     mode,
    input  logic                     pause,
    output logic                     J,
    output logic                     K,
    input  logic                     q_obs,
    output logic                     q_model,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     mismatch,
    output logic [ERR_W-1:0]         err_count
);

    localparam int LVL_W = $clog2(DEPTH) + 1;

    drv_state_t       r_state;
    logic             r_j;
    logic             r_k;
    logic             r_qModel;
    logic             r_armed;
    logic             r_mismatch;
    logic [ERR_W-1:0] r_errCount;

    logic             w_push;
    logic             w_pop;
    logic             w_popData;
    logic [LVL_W-1:0] w_level;
    logic             w_qNext;
    logic [1:0]       w_excite;

    assign tgt_ready = r_armed && (w_level < LVL_W'(DEPTH));
    assign w_push    = tgt_valid && tgt_ready;
    assign w_pop     = (r_state == DRIVE) && (w_level != '0) && !pause;

    // Excitation is taken from the Q the flop will hold after this edge, so
    // back-to-back pops chain correctly through the one-cycle J/K register.
    assign w_qNext   = jk_next(r_qModel, r_j, r_k);
    assign w_excite  = jk_excite(w_qNext, w_popData, mode);

    jk_target_fifo #(
        .DEPTH (DEPTH),
        .LVL_W (LVL_W)
    ) u_fifo (
        .clock      (clock),
        .clear      (clear),
        .i_push     (w_push),
        .i_pushData (tgt_q),
        .i_pop      (w_pop),
        .o_popData  (w_popData),
        .o_level    (w_level)
    );

    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            r_state <= IDLE;
            r_j     <= 1'b0;
            r_k     <= 1'b0;
        end else begin
            if (w_pop) begin
                r_j <= w_excite[1];
                r_k <= w_excite[0];
            end else begin
                r_j <= 1'b0;
                r_k <= 1'b0;
            end
            case (r_state)
                IDLE: begin
                    if (pause)                 r_state <= HOLD;
                    else if (w_level != '0)    r_state <= DRIVE;
                end
                DRIVE: begin
                    if (pause)
                        r_state <= HOLD;
                    else if ((w_level <= LVL_W'(1)) && !w_push)
                        r_state <= IDLE;
                end
                HOLD: begin
                    if (!pause) r_state <= (w_level != '0) ? DRIVE : IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // The external flop shares clear, so comparison starts one edge after release.
    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            r_qModel   <= 1'b0;
            r_armed    <= 1'b0;
            r_mismatch <= 1'b0;
            r_errCount <= '0;
        end else begin
            r_qModel <= w_qNext;
            r_armed  <= 1'b1;
            if (r_armed && (q_obs != r_qModel)) begin
                r_mismatch <= 1'b1;
                if (r_errCount != {ERR_W{1'b1}}) r_errCount <= r_errCount + 1'b1;
            end
        end
    end

    assign J         = r_j;
    assign K         = r_k;
    assign q_model   = r_qModel;
    assign level     = w_level;
    assign mismatch  = r_mismatch;
    assign err_count = r_errCount;

endmodule

// File: tb/tb_jk_excitation_driver.sv
// Scoreboard bench for jk_excitation_driver with an external JK flop on J/K.
import jk_pkg::*;

module tb_jk_excitation_driver;

   typedef struct {
      logic j;
      logic k;
      logic q;
   } exp_t;

   logic       clock = 1'b0;
   logic       clear = 1'b1;
   logic       tgtValid = 1'b0;
   logic       tgtQ = 1'b0;
   logic       mode = 1'b0;
   logic       pause = 1'b0;
   logic       tgtReady;
   logic       jOut;
   logic       kOut;
   logic       qObs;
   logic       qModel;
   logic [2:0] level;
   logic       mismatch;
   logic [7:0] errCount;

   logic       extQ;
   logic       forceEn = 1'b0;
   logic       forceVal = 1'b0;

   logic       clear2 = 1'b1;
   logic       qObs2 = 1'b0;
   logic       ready2;
   logic       j2;
   logic       k2;
   logic       qModel2;
   logic [2:0] level2;
   logic       mismatch2;
   logic [1:0] errCount2;

   int         testsRun = 0;
   int         testsFailed = 0;
   exp_t       expQ[$];
   logic       popPend = 1'b0;
   logic       qPend = 1'b0;
   logic       qExp = 1'b0;

   jk_excitation_driver #(.DEPTH(4), .ERR_W(8)) dut (
      .clock     (clock),
      .clear     (clear),
      .tgt_valid (tgtValid),
      .tgt_ready (tgtReady),
      .tgt_q     (tgtQ),
      .mode      (mode),
      .pause     (pause),
      .J         (jOut),
      .K         (kOut),
      .q_obs     (qObs),
      .q_model   (qModel),
      .level     (level),
      .mismatch  (mismatch),
      .err_count (errCount)
   );

   jk_excitation_driver #(.DEPTH(4), .ERR_W(2)) dutSat (
      .clock     (clock),
      .clear     (clear2),
      .tgt_valid (1'b0),
      .tgt_ready (ready2),
      .tgt_q     (1'b0),
      .mode      (1'b0),
      .pause     (1'b0),
      .J         (j2),
      .K         (k2),
      .q_obs     (qObs2),
      .q_model   (qModel2),
      .level     (level2),
      .mismatch  (mismatch2),
      .err_count (errCount2)
   );

   // Free-running clock, 10 time-unit period.
   always #5 clock = ~clock;

   // Stand-in for the external JK flop that shares clear with the driver.
   always @(posedge clock or posedge clear) begin
      if (clear)              extQ <= 1'b0;
      else if (jOut && kOut)  extQ <= ~extQ;
      else if (jOut)          extQ <= 1'b1;
      else if (kOut)          extQ <= 1'b0;
   end

   assign qObs = forceEn ? forceVal : extQ;

   task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
      testsRun++;
      if (actual !== expected) begin
         testsFailed++;
         $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
      end
   endtask

   // Monitor: a pop seen mid-cycle means J/K are due after the next edge and
   // Q one edge later; each is checked against the head of the scoreboard.
   always @(negedge clock) begin
      exp_t e;
      if (clear) begin
         popPend = 1'b0;
         qPend   = 1'b0;
      end else begin
         if (qPend) begin
            checkOutput("q_model", {15'd0, qModel}, {15'd0, qExp});
            checkOutput("ext_q", {15'd0, extQ}, {15'd0, qExp});
            qPend = 1'b0;
         end
         if (popPend) begin
            if (expQ.size() == 0) begin
               testsRun++;
               testsFailed++;
               $display("[TB] FAIL unexpected_pop: got J/K %b%b with no target queued", jOut, kOut);
            end else begin
               e = expQ.pop_front();
               checkOutput("jk", {14'd0, jOut, kOut}, {14'd0, e.j, e.k});
               qExp  = e.q;
               qPend = 1'b1;
            end
            popPend = 1'b0;
         end
         if (dut.w_pop) popPend = 1'b1;
      end
   end

   // Offers one target and records the hand-computed J/K and resulting Q.
   task automatic applyStimulus(input logic t, input logic ej, input logic ek, input logic eq);
      exp_t e;
      int   waited = 0;
      while (!tgtReady && waited < 50) begin
         @(posedge clock); #1;
         waited++;
      end
      if (!tgtReady) begin
         testsRun++;
         testsFailed++;
         $display("[TB] FAIL ready_timeout: tgt_ready stayed 0, required 1");
         return;
      end
      e.j = ej; e.k = ek; e.q = eq;
      expQ.push_back(e);
      tgtValid = 1'b1;
      tgtQ     = t;
      @(posedge clock); #1;
      tgtValid = 1'b0;
   endtask

   task automatic doClear();
      @(posedge clock); #1;
      clear = 1'b1;
      @(posedge clock); #1;
      clear = 1'b0;
      @(posedge clock); #1;
   endtask

   task automatic waitDrain(input string name);
      logic done = 1'b0;
      for (int i = 0; i < 40 && !done; i++) begin
         @(posedge clock); #1;
         if (level == 3'd0 && expQ.size() == 0 && !qPend && !popPend) done = 1'b1;
      end
      if (!done) begin
         testsRun++;
         testsFailed++;
         $display("[TB] FAIL %s: drain timeout, level %0d, %0d targets outstanding", name, level, expQ.size());
      end
      repeat (2) @(posedge clock);
      #1;
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL global_timeout: run did not finish");
      $fatal(1, "[TB] timeout");
   end

   initial begin
      // Reset state while clear is held.
      #12;
      checkOutput("rst_j", {15'd0, jOut}, 16'd0);
      checkOutput("rst_k", {15'd0, kOut}, 16'd0);
      checkOutput("rst_q_model", {15'd0, qModel}, 16'd0);
      checkOutput("rst_level", {13'd0, level}, 16'd0);
      checkOutput("rst_mismatch", {15'd0, mismatch}, 16'd0);
      checkOutput("rst_err_count", {8'd0, errCount}, 16'd0);
      checkOutput("rst_ready", {15'd0, tgtReady}, 16'd0);
      @(posedge clock); #1;
      clear  = 1'b0;
      clear2 = 1'b0;
      checkOutput("ready_before_edge", {15'd0, tgtReady}, 16'd0);
      @(posedge clock); #1;
      checkOutput("ready_after_edge", {15'd0, tgtReady}, 16'd1);

      // mode=0, targets 1,0,1,1 from Q=0.
      mode = 1'b0;
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b1);
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b1);
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
      waitDrain("drain_mode0");
      checkOutput("mismatch_mode0", {15'd0, mismatch}, 16'd0);

      // mode=1, targets 1,0,0 from Q=0.
      doClear();
      mode = 1'b1;
      applyStimulus(1'b1, 1'b1, 1'b1, 1'b1);
      applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
      waitDrain("drain_mode1");
      mode = 1'b0;
      checkOutput("mismatch_mode1", {15'd0, mismatch}, 16'd0);

      // Fill while paused, refuse the fifth, then drain in order.
      doClear();
      pause = 1'b1;
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b1);
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
      checkOutput("full_level", {13'd0, level}, 16'd4);
      checkOutput("full_ready", {15'd0, tgtReady}, 16'd0);
      checkOutput("paused_jk", {14'd0, jOut, kOut}, 16'd0);
      tgtValid = 1'b1;
      tgtQ     = 1'b1;
      @(posedge clock); #1;
      tgtValid = 1'b0;
      checkOutput("refused_level", {13'd0, level}, 16'd4);
      pause = 1'b0;
      waitDrain("drain_pause");
      checkOutput("state_idle", {15'd0, dut.r_state == IDLE}, 16'd1);

      // Streaming push+pop holds level at 2 across the pointer wrap.
      doClear();
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b1);
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
      checkOutput("flow_level_a", {13'd0, level}, 16'd2);
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
      checkOutput("flow_level_b", {13'd0, level}, 16'd2);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
      checkOutput("flow_level_c", {13'd0, level}, 16'd2);
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b1);
      checkOutput("flow_level_d", {13'd0, level}, 16'd2);
      waitDrain("drain_flow");

      // Forced Q mismatch: three edges, then sticky.
      doClear();
      forceEn  = 1'b1;
      forceVal = 1'b1;
      repeat (3) @(posedge clock);
      #1;
      forceEn = 1'b0;
      checkOutput("mismatch_set", {15'd0, mismatch}, 16'd1);
      checkOutput("err_count_3", {8'd0, errCount}, 16'd3);
      @(posedge clock); #1;
      checkOutput("mismatch_sticky", {15'd0, mismatch}, 16'd1);
      checkOutput("err_count_hold", {8'd0, errCount}, 16'd3);

      // Saturation on the 2-bit counter instance.
      qObs2 = 1'b1;
      repeat (2) @(posedge clock);
      #1;
      checkOutput("sat_count_2", {14'd0, errCount2}, 16'd2);
      repeat (3) @(posedge clock);
      #1;
      qObs2 = 1'b0;
      checkOutput("sat_count_max", {14'd0, errCount2}, 16'd3);
      checkOutput("sat_mismatch", {15'd0, mismatch2}, 16'd1);

      // Clear mid-cycle with three queued targets and Q=1.
      doClear();
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b1);
      waitDrain("drain_pre_clear");
      pause    = 1'b1;
      tgtValid = 1'b1;
      tgtQ     = 1'b0;
      repeat (3) @(posedge clock);
      #1;
      tgtValid = 1'b0;
      checkOutput("pre_clear_level", {13'd0, level}, 16'd3);
      checkOutput("pre_clear_q", {15'd0, qModel}, 16'd1);
      #2;
      clear = 1'b1;
      #1;
      checkOutput("clr_jk", {14'd0, jOut, kOut}, 16'd0);
      checkOutput("clr_level", {13'd0, level}, 16'd0);
      checkOutput("clr_q_model", {15'd0, qModel}, 16'd0);
      checkOutput("clr_ready", {15'd0, tgtReady}, 16'd0);
      @(posedge clock); #1;
      clear = 1'b0;
      pause = 1'b0;
      @(posedge clock); #1;
      checkOutput("clr_ready_after", {15'd0, tgtReady}, 16'd1);
      repeat (6) @(posedge clock);
      #1;
      checkOutput("clr_no_pop_level", {13'd0, level}, 16'd0);
      checkOutput("clr_no_pop_q", {15'd0, qModel}, 16'd0);

      checkOutput("scoreboard_empty", 16'(expQ.size()), 16'd0);
      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
